// File: rtl/lb_init_pkg.sv
// Shared types and constants for the local-bus initiator.
package lb_init_pkg;

  localparam int unsigned LB_ADDR_W  = 32;
  localparam int unsigned LB_DATA_W  = 32;
  localparam int unsigned LB_LEN_W   = 8;
  localparam int unsigned LB_BEATS_W = 9;
  localparam int unsigned LB_TIMER_W = 8;
  localparam int unsigned LB_ERR_W   = 16;

  localparam logic [LB_ADDR_W-1:0] LB_ADDR_STRIDE  = 32'd4;
  localparam logic [LB_DATA_W-1:0] LB_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_STROBE,
    S_WR_GAP,
    S_RD_STROBE,
    S_RD_WAIT,
    S_RD_PUSH
  } lb_state_e;

  typedef struct packed {
    logic                wr;
    logic [LB_ADDR_W-1:0] addr;
    logic [LB_LEN_W-1:0]  len;
  } lb_cmd_t;

endpackage

// File: rtl/lb_initiator.sv
// Local-bus initiator: turns host burst commands into lb_wr/lb_rd strobes and
// returns read replies (or a timeout marker) on a valid/ready stream.
module lb_initiator
  import lb_init_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned RD_MASK = 1,
  parameter int unsigned WR_GAP  = 2
) (
  input  logic                  clk_lb,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [LB_ADDR_W-1:0]  cmd_addr,
  input  logic [LB_LEN_W-1:0]   cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [LB_DATA_W-1:0]  wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [LB_DATA_W-1:0]  rd_data,
  output logic                  rd_err,
  output logic                  busy,
  output logic [LB_ERR_W-1:0]   err_cnt,
  output logic                  lb_wr,
  output logic                  lb_rd,
  output logic [LB_ADDR_W-1:0]  lb_addr,
  output logic [LB_DATA_W-1:0]  lb_wr_d,
  input  logic [LB_DATA_W-1:0]  lb_rd_d,
  input  logic                  lb_rd_rdy
);

  localparam logic [LB_TIMER_W-1:0] TIMEOUT_C = LB_TIMER_W'(TIMEOUT);
  localparam logic [LB_TIMER_W-1:0] RD_MASK_C = LB_TIMER_W'(RD_MASK);
  localparam logic [LB_TIMER_W:0]   WR_GAP_C  = (LB_TIMER_W+1)'(WR_GAP);

  lb_state_e             state_q, state_d;
  logic [LB_ADDR_W-1:0]  addr_q, addr_d;
  logic [LB_BEATS_W-1:0] beats_q, beats_d;
  logic [LB_TIMER_W-1:0] timer_q, timer_d;
  logic [LB_ADDR_W-1:0]  lb_addr_q, lb_addr_d;
  logic [LB_DATA_W-1:0]  lb_wdata_q, lb_wdata_d;
  logic [LB_DATA_W-1:0]  rd_data_q, rd_data_d;
  logic                  rd_err_q, rd_err_d;
  logic [LB_ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic                  cmd_ready_q, wd_ready_q, rd_valid_q, busy_q, lb_wr_q, lb_rd_q;

  lb_cmd_t cmd;
  logic    gap_done;
  logic    last_beat;

  assign cmd       = '{wr: cmd_wr, addr: cmd_addr, len: cmd_len};
  assign gap_done  = ({1'b0, timer_q} + (LB_TIMER_W+1)'(1)) >= WR_GAP_C;
  assign last_beat = (beats_q == LB_BEATS_W'(1));

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    timer_d    = timer_q;
    lb_addr_d  = lb_addr_q;
    lb_wdata_d = lb_wdata_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd.addr;
          beats_d = LB_BEATS_W'(cmd.len) + LB_BEATS_W'(1);
          state_d = cmd.wr ? S_WR_DATA : S_RD_STROBE;
        end
      end
      S_WR_DATA: begin
        if (wd_valid && wd_ready_q) begin
          lb_wdata_d = wd_data;
          state_d    = S_WR_STROBE;
        end
      end
      S_WR_STROBE: begin
        timer_d = '0;
        state_d = S_WR_GAP;
      end
      S_WR_GAP: begin
        if (gap_done) begin
          addr_d  = addr_q + LB_ADDR_STRIDE;
          beats_d = beats_q - LB_BEATS_W'(1);
          state_d = last_beat ? S_IDLE : S_WR_DATA;
        end else begin
          timer_d = timer_q + LB_TIMER_W'(1);
        end
      end
      S_RD_STROBE: begin
        // Strobe cycle is cycle 0; the first wait cycle is cycle 1.
        timer_d = LB_TIMER_W'(1);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if ((timer_q > RD_MASK_C) && lb_rd_rdy) begin
          rd_data_d = lb_rd_d;
          rd_err_d  = 1'b0;
          state_d   = S_RD_PUSH;
        end else if (timer_q >= TIMEOUT_C) begin
          rd_data_d = LB_TIMEOUT_DATA;
          rd_err_d  = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + LB_ERR_W'(1);
          state_d   = S_RD_PUSH;
        end else begin
          timer_d = timer_q + LB_TIMER_W'(1);
        end
      end
      S_RD_PUSH: begin
        if (rd_ready && rd_valid_q) begin
          addr_d  = addr_q + LB_ADDR_STRIDE;
          beats_d = beats_q - LB_BEATS_W'(1);
          state_d = last_beat ? S_IDLE : S_RD_STROBE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_WR_STROBE) || (state_d == S_RD_STROBE)) lb_addr_d = addr_d;
  end

  // State and registered outputs; strobes/readies decode the upcoming state.
  always_ff @(posedge clk_lb or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      timer_q     <= '0;
      lb_addr_q   <= '0;
      lb_wdata_q  <= '0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      err_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      wd_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      lb_wr_q     <= 1'b0;
      lb_rd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      timer_q     <= timer_d;
      lb_addr_q   <= lb_addr_d;
      lb_wdata_q  <= lb_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
      err_cnt_q   <= err_cnt_d;
      cmd_ready_q <= (state_d == S_IDLE);
      wd_ready_q  <= (state_d == S_WR_DATA);
      rd_valid_q  <= (state_d == S_RD_PUSH);
      busy_q      <= (state_d != S_IDLE);
      lb_wr_q     <= (state_d == S_WR_STROBE);
      lb_rd_q     <= (state_d == S_RD_STROBE);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wd_ready  = wd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;
  assign lb_wr     = lb_wr_q;
  assign lb_rd     = lb_rd_q;
  assign lb_addr   = lb_addr_q;
  assign lb_wr_d   = lb_wdata_q;

endmodule
